display_scanner: RTL

- Parametrised time-multiplexed 7-segment scan controller, the successor to the fixed 4-digit, 2-bank rotator.
- Drives NUM_DIGITS common-anode digits from NUM_PAGES banks of BCD/hex nibbles.
- Page switching is glitch-free and takes effect only at frame boundaries. Also provides per-digit decimal points, leading-zero suppression, inter-digit dead time (anti-ghosting), PWM brightness and a frame-tick output.
- Sits between the calculator datapath and the segment decoder.

---
 rtl/display_scanner.sv | 125 ++++++++++++
 1 files changed

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// display_scanner : time-multiplexed 7-segment scan controller with paged
//                   digit banks, LZ blanking, dead time and PWM brightness.
// Revision        : 1.0
// ============================================================================
module display_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int NUM_PAGES    = 2,
  parameter int SCAN_DIV     = 2048,
  parameter int BLANK_CYCLES = 16,
  parameter int BRIGHT_W     = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NUM_PAGES*NUM_DIGITS*4-1:0]                 digits,
  input  logic [NUM_PAGES*NUM_DIGITS-1:0]                   dp_mask,
  input  logic [((NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1)-1:0] page_sel,
  input  logic                                              lz_suppress,
  input  logic [BRIGHT_W-1:0]                               brightness,
  output logic [NUM_DIGITS-1:0]                             an,
  output logic [3:0]                                        digit_out,
  output logic                                              dp_n,
  output logic                                              blank,
  output logic                                              frame_tick
);

  localparam int PRE_W   = $clog2(SCAN_DIV);
  localparam int SLOT_W  = $clog2(NUM_DIGITS);
  localparam int PAGE_W  = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [PAGE_W-1:0]     page_q, page_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            digit_q, digit_d;
  logic                  dp_q, dp_d;
  logic                  blank_q, blank_d;
  logic                  tick_q, tick_d;

  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  upper_zero;
  logic                  dead, pwm_off, suppressed, off;

  // Page requests are only honoured as the last slot of a frame wraps.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    slot_d  = slot_q;
    page_d  = page_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      if (slot_q == SLOT_W'(NUM_DIGITS - 1)) begin
        slot_d = '0;
        if ({1'b0, page_sel} < (PAGE_W + 1)'(NUM_PAGES)) begin
          page_d = page_sel;
        end
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_comb begin
    nib_sel    = '0;
    dp_sel     = 1'b0;
    upper_zero = 1'b1;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (PAGE_W'(p) == page_q) begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (SLOT_W'(d) == slot_q) begin
            nib_sel = digits[(p*NUM_DIGITS + d)*4 +: 4];
            dp_sel  = dp_mask[p*NUM_DIGITS + d];
          end
          if ((SLOT_W'(d) >= slot_q) && (digits[(p*NUM_DIGITS + d)*4 +: 4] != 4'h0)) begin
            upper_zero = 1'b0;
          end
        end
      end
    end
  end

  assign dead       = (presc_q < PRE_W'(BLANK_CYCLES));
  assign pwm_off    = (brightness != '1) && (presc_q[PRE_W-1 -: BRIGHT_W] >= brightness);
  assign suppressed = lz_suppress && (slot_q != '0) && upper_zero;
  assign off        = dead | pwm_off | suppressed;

  always_comb begin
    an_d    = off ? '1 : ~(NUM_DIGITS'(1) << slot_q);
    digit_d = nib_sel;
    dp_d    = off ? 1'b1 : ~dp_sel;
    blank_d = off;
    tick_d  = (presc_q == '0) && (slot_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      slot_q  <= '0;
      page_q  <= '0;
      an_q    <= '1;
      digit_q <= '0;
      dp_q    <= 1'b1;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      page_q  <= page_d;
      an_q    <= an_d;
      digit_q <= digit_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

  assign an         = an_q;
  assign digit_out  = digit_q;
  assign dp_n       = dp_q;
  assign blank      = blank_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire
